// File: rtl/frame_fetch_fifo.sv
// frame_fetch_fifo: prefetch buffer between the RP2040 framebuffer bus
// and the VGA raster; strobes the framebuffer and queues pixels.
module frame_fetch_fifo #(
   parameter int DEPTH        = 4,
   parameter int PIXEL_BITS   = 4,
   parameter int SAMPLE_DELAY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic                  pop,
   output logic [PIXEL_BITS-1:0] pixel_out,
   output logic                  pixel_valid,
   output logic                  underflow,
   output logic                  frame_reset_out,
   output logic                  frame_next_pixel_out,
   input  logic [PIXEL_BITS-1:0] frame_pixel_in
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [3:0] DLY = 4'(SAMPLE_DELAY);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE
   } state_t;

   state_t state_q, state_d;
   logic [3:0] dly_q, dly_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic uf_q, uf_d;
   logic rst_str_q, rst_str_d;
   logic nxt_str_q, nxt_str_d;
   logic [PIXEL_BITS-1:0] mem_q [DEPTH];

   logic push;
   logic flush;
   logic full;
   logic empty;
   logic pop_ok;
   logic pop_empty;

   assign full      = (count_q == FULL);
   assign empty     = (count_q == '0);
   assign pop_ok    = pop && !frame_start && !empty;
   assign pop_empty = pop && !frame_start && empty;

   // Fetch sequencer: strobes, settle countdown and capture decision.
   always_comb begin
      state_d   = state_q;
      dly_d     = dly_q;
      push      = 1'b0;
      flush     = 1'b0;
      rst_str_d = 1'b0;
      nxt_str_d = 1'b0;
      if (frame_start) begin
         flush     = 1'b1;
         rst_str_d = 1'b1;
         state_d   = SETTLE;
         dly_d     = DLY;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            SETTLE: begin
               dly_d = dly_q - 4'd1;
               if (dly_q == 4'd1) begin
                  state_d = SAMPLE;
               end
            end
            SAMPLE: begin
               if (!full) begin
                  push      = 1'b1;
                  nxt_str_d = 1'b1;
                  state_d   = SETTLE;
                  dly_d     = DLY;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // FIFO bookkeeping: pointers, occupancy and sticky underflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      uf_d     = uf_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         uf_d     = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (pop_empty) begin
            uf_d = 1'b1;
         end
         unique case ({push, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         dly_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         uf_q      <= 1'b0;
         rst_str_q <= 1'b0;
         nxt_str_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dly_q     <= dly_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         uf_q      <= uf_d;
         rst_str_q <= rst_str_d;
         nxt_str_q <= nxt_str_d;
      end
   end

   // Pixel storage, written at the write pointer on each capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= frame_pixel_in;
      end
   end

   assign pixel_valid          = !empty;
   assign pixel_out            = empty ? '0 : mem_q[rd_ptr_q];
   assign underflow            = uf_q;
   assign frame_reset_out      = rst_str_q;
   assign frame_next_pixel_out = nxt_str_q;

endmodule

// File: tb/tb_frame_fetch_fifo.sv
// tb_frame_fetch_fifo: vector table, directed corners and random
// traffic checked against a queue-based model of the fetch buffer.
module tb_frame_fetch_fifo;

   localparam int DEPTH = 4;
   localparam int PB    = 4;
   localparam int D     = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_start = 1'b0;
   logic pop = 1'b0;
   logic [PB-1:0] frame_pixel_in = '0;
   logic [PB-1:0] pixel_out;
   logic pixel_valid;
   logic underflow;
   logic frame_reset_out;
   logic frame_next_pixel_out;

   frame_fetch_fifo #(
      .DEPTH(DEPTH),
      .PIXEL_BITS(PB),
      .SAMPLE_DELAY(D)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .frame_start(frame_start),
      .pop(pop),
      .pixel_out(pixel_out),
      .pixel_valid(pixel_valid),
      .underflow(underflow),
      .frame_reset_out(frame_reset_out),
      .frame_next_pixel_out(frame_next_pixel_out),
      .frame_pixel_in(frame_pixel_in)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state
   int mq[$];
   bit m_act = 0;
   int m_next = 0;
   int m_edge = 0;
   bit m_uf = 0;
   bit m_rs = 0;
   bit m_nx = 0;
   int m_caps = 0;

   typedef struct {
      logic fs;
      logic pp;
      logic [PB-1:0] pix;
      logic ev;
      logic [PB-1:0] epx;
      logic ers;
      logic enx;
      logic euf;
   } vec_t;

   vec_t tq[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit cap;
      if (!rst_n) begin
         mq.delete();
         m_act = 0;
         m_uf = 0;
         m_rs = 0;
         m_nx = 0;
      end else if (frame_start) begin
         mq.delete();
         m_uf = 0;
         m_act = 1;
         m_next = m_edge + D + 1;
         m_rs = 1;
         m_nx = 0;
         m_caps = 0;
      end else begin
         cap = m_act && (m_edge >= m_next) && (mq.size() < DEPTH);
         m_rs = 0;
         m_nx = 0;
         if (pop) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else m_uf = 1;
         end
         if (cap) begin
            mq.push_back(int'(frame_pixel_in));
            m_next = m_edge + D + 1;
            m_nx = 1;
            m_caps++;
         end
      end
      m_edge++;
   endtask

   task automatic check_model();
      chk("valid", int'(pixel_valid), int'(mq.size() != 0));
      chk("pixel", int'(pixel_out), (mq.size() != 0) ? mq[0] : 0);
      chk("underflow", int'(underflow), int'(m_uf));
      chk("reset_strobe", int'(frame_reset_out), int'(m_rs));
      chk("next_strobe", int'(frame_next_pixel_out), int'(m_nx));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic row(input logic fs, input logic pp,
                      input logic [PB-1:0] pix, input logic ev,
                      input logic [PB-1:0] epx, input logic ers,
                      input logic enx);
      vec_t v;
      v.fs = fs; v.pp = pp; v.pix = pix;
      v.ev = ev; v.epx = epx; v.ers = ers; v.enx = enx; v.euf = 1'b0;
      tq.push_back(v);
   endtask

   task automatic idle_in();
      frame_start = 1'b0;
      pop = 1'b0;
   endtask

   initial begin
      bit reached;
      int expv;
      int pops;

      // fill / stall / pop table, edge E0 first
      row(1, 0, 4'h3, 0, 4'h0, 1, 0);
      row(0, 0, 4'h3, 0, 4'h0, 0, 0);
      row(0, 0, 4'h3, 0, 4'h0, 0, 0);
      row(0, 0, 4'h3, 1, 4'h3, 0, 1);
      row(0, 0, 4'h7, 1, 4'h3, 0, 0);
      row(0, 0, 4'h7, 1, 4'h3, 0, 0);
      row(0, 0, 4'h7, 1, 4'h3, 0, 1);
      row(0, 0, 4'hA, 1, 4'h3, 0, 0);
      row(0, 0, 4'hA, 1, 4'h3, 0, 0);
      row(0, 0, 4'hA, 1, 4'h3, 0, 1);
      row(0, 0, 4'hF, 1, 4'h3, 0, 0);
      row(0, 0, 4'hF, 1, 4'h3, 0, 0);
      row(0, 0, 4'hF, 1, 4'h3, 0, 1);
      for (int i = 13; i < 20; i++) row(0, 0, 4'hF, 1, 4'h3, 0, 0);
      row(0, 1, 4'h5, 1, 4'h7, 0, 0);
      row(0, 0, 4'h5, 1, 4'h7, 0, 1);
      row(0, 0, 4'h5, 1, 4'h7, 0, 0);

      // reset state
      cyc();
      cyc();
      chk("rst_valid", int'(pixel_valid), 0);
      chk("rst_pixel", int'(pixel_out), 0);
      chk("rst_uf", int'(underflow), 0);
      chk("rst_rs", int'(frame_reset_out), 0);
      chk("rst_nx", int'(frame_next_pixel_out), 0);
      #4 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cyc();

      // table-driven fill
      foreach (tq[i]) begin
         frame_start = tq[i].fs;
         pop = tq[i].pp;
         frame_pixel_in = tq[i].pix;
         cyc();
         chk($sformatf("tbl%0d_valid", i), int'(pixel_valid), int'(tq[i].ev));
         chk($sformatf("tbl%0d_pixel", i), int'(pixel_out), int'(tq[i].epx));
         chk($sformatf("tbl%0d_rs", i), int'(frame_reset_out), int'(tq[i].ers));
         chk($sformatf("tbl%0d_nx", i), int'(frame_next_pixel_out), int'(tq[i].enx));
         chk($sformatf("tbl%0d_uf", i), int'(underflow), int'(tq[i].euf));
      end
      idle_in();
      // drain remaining 7, A, F, 5 in order
      frame_pixel_in = 4'h1;
      pop = 1'b1;
      cyc(); chk("drain_a", int'(pixel_out), 'hA);
      cyc(); chk("drain_f", int'(pixel_out), 'hF);
      pop = 1'b0;

      // underflow
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      pop = 1'b1;
      frame_pixel_in = 4'h9;
      cyc();
      chk("uf_set", int'(underflow), 1);
      chk("uf_pixel", int'(pixel_out), 0);
      pop = 1'b0;
      cyc();
      cyc();
      chk("uf_sticky", int'(underflow), 1);
      chk("uf_head", int'(pixel_out), 'h9);

      // clear by frame_start, then restart mid-fill with pop
      frame_start = 1'b1;
      cyc();
      chk("uf_clear", int'(underflow), 0);
      frame_start = 1'b0;
      reached = 0;
      for (int i = 0; i < 40 && !reached; i++) begin
         frame_pixel_in = 4'(i);
         cyc();
         if (mq.size() == 3) reached = 1;
      end
      chk("wait_fill3", int'(reached), 1);
      frame_start = 1'b1;
      pop = 1'b1;
      cyc();
      chk("rs_valid", int'(pixel_valid), 0);
      chk("rs_uf", int'(underflow), 0);
      chk("rs_strobe", int'(frame_reset_out), 1);
      idle_in();
      cyc(); chk("rs_nx1", int'(frame_next_pixel_out), 0);
      cyc(); chk("rs_nx2", int'(frame_next_pixel_out), 0);
      cyc(); chk("rs_nx3", int'(frame_next_pixel_out), 1);

      // reset mid-fill
      reached = 0;
      for (int i = 0; i < 40 && !reached; i++) begin
         cyc();
         if (mq.size() == 2) reached = 1;
      end
      chk("wait_fill2", int'(reached), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(pixel_valid), 0);
      chk("arst_pixel", int'(pixel_out), 0);
      chk("arst_uf", int'(underflow), 0);
      chk("arst_rs", int'(frame_reset_out), 0);
      chk("arst_nx", int'(frame_next_pixel_out), 0);
      cyc();
      cyc();
      #4 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) cyc();

      // steady stream: pop every 3 cycles, incrementing bus
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      frame_pixel_in = 4'(m_caps);
      expv = 0;
      pops = 0;
      for (int t = 1; t < 400 && pops < 64; t++) begin
         pop = (t >= 4) && (t % 3 == 1);
         if (pop) begin
            chk("stream_head", int'(pixel_out), expv % 16);
            expv++;
            pops++;
         end
         cyc();
         frame_pixel_in = 4'(m_caps);
      end
      pop = 1'b0;
      chk("stream_pops", pops, 64);
      chk("stream_uf", int'(underflow), 0);

      // random traffic
      frame_start = 1'b1;
      for (int i = 0; i < 600; i++) begin
         pop = ($urandom_range(0, 2) == 0);
         frame_pixel_in = 4'($urandom);
         cyc();
         frame_start = ($urandom_range(0, 59) == 0);
      end
      idle_in();
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frame_fetch_fifo.md
# frame_fetch_fifo

Prefetch buffer between the RP2040 framebuffer pins and the VGA raster logic. Generates the framebuffer strobes `frame_reset_out` and `frame_next_pixel_out`, samples `frame_pixel_in` after a programmable settle delay, and stores pixels in a small FIFO. The raster pops pixels on demand, so RP2040 bus latency is decoupled from the pixel clock. Runs in the `clk` domain, alongside the VGA generator.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `PIXEL_BITS`, 4: gray-level width.
- `SAMPLE_DELAY`, 2: settle cycles granted to the RP2040 after each strobe; legal range 1..15.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `frame_start`  in  1  one-cycle pulse from the raster; flushes the FIFO and rewinds the framebuffer.
- `pop`  in  1  raster consumes the head pixel on this edge.
- `pixel_out`  out  PIXEL_BITS  head entry; 0 when empty.
- `pixel_valid`  out  1  FIFO non-empty.
- `underflow`  out  1  sticky flag: pop while empty.
- `frame_reset_out`  out  1  rewind strobe to RP2040.
- `frame_next_pixel_out`  out  1  advance strobe to RP2040.
- `frame_pixel_in`  in  PIXEL_BITS  pixel bus from RP2040.

## Operation
- **States:**
  - IDLE: after reset, no fetching.
  - SETTLE: counting down the settle delay.
  - SAMPLE: ready to capture.
- **FIFO:**
  - Registered read/write pointers, log2(DEPTH) bits each, wrapping modulo DEPTH.
  - Occupancy count is log2(DEPTH)+1 bits.
- **frame_start (any state):** on that edge:
  - Clear pointers and count.
  - Clear `underflow`.
  - Assert `frame_reset_out` for the following cycle.
  - Go to SETTLE with counter = SAMPLE_DELAY.
  - A `pop` on the same edge is ignored and does not set `underflow`.
- **SETTLE:** decrement the counter each edge. Move to SAMPLE on the edge where the counter reaches 0.
- **SAMPLE, count < DEPTH (pre-edge value):**
  - Write `frame_pixel_in` at the write pointer.
  - Assert `frame_next_pixel_out` for the following cycle.
  - Return to SETTLE with counter = SAMPLE_DELAY.
- **SAMPLE, FIFO full:** hold in SAMPLE with no strobe. Capture on the first edge where the pre-edge count < DEPTH. A pop therefore frees space one edge before the capture.
- **Pop:**
  - Non-empty: advance the read pointer.
  - Empty: no pointer change; set `underflow`.
- **Push and pop on the same edge:** count unchanged, data order preserved.
- **Outputs:** `pixel_out` and `pixel_valid` are derived combinationally from registered pointers and count. No read-through of `frame_pixel_in`.

## Timing
- **Reset (`rst_n`=0):** immediately forces all outputs to 0, state IDLE, pointers and count 0. Same behaviour when asserted mid-fill.
- **First frame_start at edge E0:**
  - `frame_reset_out` is high during E0..E0+1 only.
  - First sample at edge E0+SAMPLE_DELAY+1.
  - `pixel_valid` rises after that edge.
- **Each sample at edge Ek:**
  - `frame_next_pixel_out` is high during Ek..Ek+1.
  - Next sample at Ek+SAMPLE_DELAY+1 if space is available.
- **Throughput:** one pixel per SAMPLE_DELAY+1 cycles.
- **Latency:** pop to visible next head is 0 cycles (combinational head after the pointer update).
- **Strobe exclusivity:** the two strobes are never high in the same cycle, and neither is high while full-stalled or in IDLE.

## Test plan
- **Reset mid-fill:** drive `rst_n` low with 2 entries → all outputs 0 asynchronously. After release, no strobes until `frame_start`.
- **Fill (DEPTH=4, SAMPLE_DELAY=2):**
  - Stimulus: `frame_start` at E0; bus values 0x3, 0x7, 0xA, 0xF, each presented before its sample edge.
  - Captures: at E3, E6, E9, E12.
  - Strobes: `frame_next_pixel_out` high after each capture; `frame_reset_out` high only E0..E1.
  - Outputs: `pixel_out`=0x3 after E3; `pixel_valid`=1 from E3.
  - Stall: no further strobes once full.
- **Full stall and pop:** from full, pop at E20 → `pixel_out`=0x7; capture and strobe at E21; count returns to 4.
- **Underflow:** pop with FIFO empty → `underflow`=1 and stays 1, `pixel_out`=0, pointers unchanged. Next `frame_start` clears `underflow`.
- **Restart mid-fill:** `frame_start` with 3 entries and a simultaneous pop → `pixel_valid`=0 next cycle, `underflow` remains 0, `frame_reset_out` pulses, first new capture at +SAMPLE_DELAY+1.
- **Steady stream:** pop every 3 cycles for 64 pixels with an incrementing bus pattern → output sequence exact, no underflow, count oscillates between 0 and 1.
